// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: latches the result at start,
// holds busy for a fixed latency, then commits HI/LO and pulses done.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      r_state, w_stateNext;
  logic [3:0]  r_count, w_countNext;
  logic        r_busy, w_busyNext;
  logic        r_done, w_doneNext;
  logic [31:0] r_hi, w_hiNext;
  logic [31:0] r_lo, w_loNext;
  logic [31:0] r_pendHi, w_pendHiNext;
  logic [31:0] r_pendLo, w_pendLoNext;

  logic [63:0] w_prodS;
  logic [63:0] w_prodU;
  logic        w_divZero;
  logic        w_divOvf;
  logic [31:0] w_quoS, w_remS, w_quoU, w_remU;

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned product the signed product.
  assign w_prodS   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign w_prodU   = {32'b0, src_a} * {32'b0, src_b};
  assign w_divZero = (src_b == 32'd0);
  assign w_divOvf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  always_comb begin
    w_quoS = 32'd0;
    w_remS = 32'd0;
    w_quoU = 32'd0;
    w_remU = 32'd0;
    if (w_divOvf) begin
      w_quoS = 32'h8000_0000;
    end else if (!w_divZero) begin
      w_quoS = $signed(src_a) / $signed(src_b);
      w_remS = $signed(src_a) % $signed(src_b);
    end
    if (!w_divZero) begin
      w_quoU = src_a / src_b;
      w_remU = src_a % src_b;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_countNext  = r_count;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
    w_hiNext     = r_hi;
    w_loNext     = r_lo;
    w_pendHiNext = r_pendHi;
    w_pendLoNext = r_pendLo;
    case (r_state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              w_pendHiNext = (op == 3'd0) ? w_prodS[63:32] : w_prodU[63:32];
              w_pendLoNext = (op == 3'd0) ? w_prodS[31:0]  : w_prodU[31:0];
              w_countNext  = 4'(MULT_CYCLES);
              w_busyNext   = 1'b1;
              w_stateNext  = RUN;
            end
            3'd2, 3'd3: begin
              // A zero divisor still takes the full latency but recommits the current HI/LO.
              if (w_divZero) begin
                w_pendHiNext = r_hi;
                w_pendLoNext = r_lo;
              end else begin
                w_pendHiNext = (op == 3'd2) ? w_remS : w_remU;
                w_pendLoNext = (op == 3'd2) ? w_quoS : w_quoU;
              end
              w_countNext  = 4'(DIV_CYCLES);
              w_busyNext   = 1'b1;
              w_stateNext  = RUN;
            end
            3'd4:    w_hiNext = src_a;
            3'd5:    w_loNext = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (r_count == 4'd1) begin
          w_hiNext    = r_pendHi;
          w_loNext    = r_pendLo;
          w_busyNext  = 1'b0;
          w_doneNext  = 1'b1;
          w_countNext = 4'd0;
          w_stateNext = IDLE;
        end else begin
          w_countNext = r_count - 4'd1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_pendHi <= 32'd0;
      r_pendLo <= 32'd0;
    end else begin
      r_state  <= w_stateNext;
      r_count  <= w_countNext;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
      r_hi     <= w_hiNext;
      r_lo     <= w_loNext;
      r_pendHi <= w_pendHiNext;
      r_pendLo <= w_pendLoNext;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, done pulse, HI/LO arithmetic,
// mthi/mtlo, reset during RUN and starts issued while busy.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int checkCount;
  int errorCount;

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives a one-cycle start at a falling edge; returns at the falling edge after the start edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs a busy command and watches a fixed window for latency, done count and HI/LO hold.
  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int expBusy, input logic [31:0] expHi, input logic [31:0] expLo);
    int busyCnt;
    int doneCnt;
    logic holdOk;
    logic [31:0] oldHi;
    logic [31:0] oldLo;
    busyCnt = 0;
    doneCnt = 0;
    holdOk  = 1'b1;
    oldHi   = hi;
    oldLo   = lo;
    applyStimulus(o, a, b);
    for (int i = 0; i < expBusy + 3; i++) begin
      if (busy) begin
        busyCnt++;
        if (hi !== oldHi || lo !== oldLo) holdOk = 1'b0;
        if (done) doneCnt = doneCnt + 100;
      end
      if (done) doneCnt++;
      if (i < expBusy + 2) @(negedge clk);
    end
    checkOutput({tag, "_busyCycles"}, 32'(busyCnt), 32'(expBusy));
    checkOutput({tag, "_donePulses"}, 32'(doneCnt), 32'd1);
    checkOutput({tag, "_holdDuringBusy"}, {31'd0, holdOk}, 32'd1);
    checkOutput({tag, "_hi"}, hi, expHi);
    checkOutput({tag, "_lo"}, lo, expLo);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    reset = 1'b0;

    runOp("mult_neg", 3'd0, 32'hFFFF_FFFF, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    runOp("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    runOp("divu_zero", 3'd3, 32'h0000_1234, 32'd0, 10, 32'h0000_0000, 32'h8000_0000);
    runOp("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    applyStimulus(3'd4, 32'h1234_5678, 32'd0);
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    checkOutput("mthi_done", {31'd0, done}, 32'd0);
    applyStimulus(3'd5, 32'hCAFE_BABE, 32'd0);
    checkOutput("mtlo_lo", lo, 32'hCAFE_BABE);
    checkOutput("mtlo_hi", hi, 32'h1234_5678);
    checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
    checkOutput("mtlo_done", {31'd0, done}, 32'd0);

    // Reserved opcode must leave everything alone.
    applyStimulus(3'd6, 32'hFFFF_0000, 32'd1);
    checkOutput("rsvd_busy", {31'd0, busy}, 32'd0);
    checkOutput("rsvd_hi", hi, 32'h1234_5678);
    checkOutput("rsvd_lo", lo, 32'hCAFE_BABE);

    // Reset asserted in the third busy cycle clears everything without a done.
    applyStimulus(3'd0, 32'd4, 32'd4);
    repeat (2) @(negedge clk);
    checkOutput("prerst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_hi", hi, 32'd0);
    checkOutput("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int doneSeen;
      doneSeen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (done || busy) doneSeen++;
      end
      checkOutput("postrst_quiet", 32'(doneSeen), 32'd0);
    end
    checkOutput("postrst_lo", lo, 32'd0);
    applyStimulus(3'd5, 32'hA5A5_A5A5, 32'd0);
    checkOutput("postrst_mtlo", lo, 32'hA5A5_A5A5);

    // A start issued while busy must be ignored.
    applyStimulus(3'd4, 32'h1111_1111, 32'd0);
    applyStimulus(3'd0, 32'd2, 32'd3);
    applyStimulus(3'd4, 32'hDEAD_BEEF, 32'd0);
    checkOutput("busystart_hi", hi, 32'h1111_1111);
    checkOutput("busystart_busy", {31'd0, busy}, 32'd1);
    begin
      int waitCnt;
      waitCnt = 0;
      while (!done && waitCnt < 20) begin
        @(negedge clk);
        waitCnt++;
      end
      checkOutput("busystart_doneSeen", {31'd0, done}, 32'd1);
    end
    checkOutput("busystart_finalHi", hi, 32'd0);
    checkOutput("busystart_finalLo", lo, 32'd6);

    // Back-to-back: mthi in the done cycle is accepted.
    start = 1'b1;
    op    = 3'd4;
    src_a = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_hi", hi, 32'h0BAD_F00D);
    checkOutput("b2b_doneCleared", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
